// File: rtl/axi_ram_slave.sv
// AXI4 slave front-end for a dual-port byte-enabled RAM: AW/W/B drive port a, AR/R read port b.
// A 2-entry FIFO absorbs the RAM's 1-cycle read latency under R backpressure.
module axi_ram_slave #(
  parameter int ADDR_WIDTH     = 16,
  parameter int BATCH_WIDTH    = 4,
  parameter int BYTE_WIDTH     = 8,
  parameter int ID_WIDTH       = 4,
  parameter int AXI_ADDR_WIDTH = 32
) (
  input  logic                                aclk_i,
  input  logic                                aresetn_i,
  input  logic [ID_WIDTH-1:0]                 awid_i,
  input  logic [AXI_ADDR_WIDTH-1:0]           awaddr_i,
  input  logic [7:0]                          awlen_i,
  input  logic [1:0]                          awburst_i,
  input  logic                                awvalid_i,
  output logic                                awready_o,
  input  logic [BYTE_WIDTH*BATCH_WIDTH-1:0]   wdata_i,
  input  logic [BATCH_WIDTH-1:0]              wstrb_i,
  input  logic                                wlast_i,
  input  logic                                wvalid_i,
  output logic                                wready_o,
  output logic [ID_WIDTH-1:0]                 bid_o,
  output logic [1:0]                          bresp_o,
  output logic                                bvalid_o,
  input  logic                                bready_i,
  input  logic [ID_WIDTH-1:0]                 arid_i,
  input  logic [AXI_ADDR_WIDTH-1:0]           araddr_i,
  input  logic [7:0]                          arlen_i,
  input  logic [1:0]                          arburst_i,
  input  logic                                arvalid_i,
  output logic                                arready_o,
  output logic [ID_WIDTH-1:0]                 rid_o,
  output logic [BYTE_WIDTH*BATCH_WIDTH-1:0]   rdata_o,
  output logic [1:0]                          rresp_o,
  output logic                                rlast_o,
  output logic                                rvalid_o,
  input  logic                                rready_i,
  output logic [ADDR_WIDTH-1:0]               ram_addr_a_o,
  output logic [BYTE_WIDTH*BATCH_WIDTH-1:0]   ram_wdata_a_o,
  output logic [BATCH_WIDTH-1:0]              ram_be_a_o,
  output logic                                ram_we_a_o,
  output logic [ADDR_WIDTH-1:0]               ram_addr_b_o,
  input  logic [BYTE_WIDTH*BATCH_WIDTH-1:0]   ram_rdata_b_i
);
  localparam int DATA_W = BYTE_WIDTH * BATCH_WIDTH;
  localparam int OFF    = (BATCH_WIDTH > 1) ? $clog2(BATCH_WIDTH) : 0;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_ISSUE} r_state_e;

  // ---------------- write side ----------------
  w_state_e              w_state_q;
  logic [ID_WIDTH-1:0]   w_id_q;
  logic [ADDR_WIDTH-1:0] w_addr_q;
  logic [7:0]            w_len_q, w_cnt_q;
  logic                  w_fixed_q, w_err_q;
  logic                  awready_q, wready_q, bvalid_q;
  logic [1:0]            bresp_q;
  logic [ID_WIDTH-1:0]   bid_q;
  logic                  w_last_beat, w_err_d;

  assign w_last_beat = (w_cnt_q == w_len_q);
  assign w_err_d     = w_err_q | (wlast_i != w_last_beat);

  always_ff @(posedge aclk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      w_state_q <= W_IDLE;
      w_id_q    <= '0;
      w_addr_q  <= '0;
      w_len_q   <= '0;
      w_cnt_q   <= '0;
      w_fixed_q <= 1'b0;
      w_err_q   <= 1'b0;
      awready_q <= 1'b1;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      bid_q     <= '0;
    end else begin
      case (w_state_q)
        W_IDLE: if (awvalid_i) begin
          w_id_q    <= awid_i;
          w_addr_q  <= awaddr_i[ADDR_WIDTH+OFF-1:OFF];
          w_len_q   <= awlen_i;
          w_fixed_q <= (awburst_i == 2'b00);
          w_cnt_q   <= '0;
          w_err_q   <= 1'b0;
          awready_q <= 1'b0;
          wready_q  <= 1'b1;
          w_state_q <= W_DATA;
        end
        W_DATA: if (wvalid_i) begin
          w_err_q <= w_err_d;
          if (!w_fixed_q) w_addr_q <= w_addr_q + 1'b1;
          // Beat count alone closes the burst; a misplaced wlast only flags SLVERR.
          if (w_last_beat) begin
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b1;
            bid_q     <= w_id_q;
            bresp_q   <= w_err_d ? 2'b10 : 2'b00;
            w_state_q <= W_RESP;
          end else begin
            w_cnt_q <= w_cnt_q + 8'd1;
          end
        end
        W_RESP: if (bready_i) begin
          bvalid_q  <= 1'b0;
          awready_q <= 1'b1;
          w_state_q <= W_IDLE;
        end
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  assign awready_o     = awready_q;
  assign wready_o      = wready_q;
  assign bvalid_o      = bvalid_q;
  assign bresp_o       = bresp_q;
  assign bid_o         = bid_q;
  assign ram_we_a_o    = wready_q & wvalid_i;
  assign ram_addr_a_o  = w_addr_q;
  assign ram_wdata_a_o = wdata_i;
  assign ram_be_a_o    = wstrb_i;

  // ---------------- read side ----------------
  r_state_e              r_state_q;
  logic                  arready_q;
  logic [ADDR_WIDTH-1:0] r_addr_q;
  logic [7:0]            r_len_q, r_cnt_q;
  logic                  r_fixed_q;
  logic [ID_WIDTH-1:0]   r_id_q;
  logic                  infl_q, infl_last_q;
  logic [ID_WIDTH-1:0]   infl_id_q;

  logic [DATA_W-1:0]     fifo_data_q [2];
  logic [ID_WIDTH-1:0]   fifo_id_q   [2];
  logic                  fifo_last_q [2];
  logic                  wr_ptr_q, rd_ptr_q;
  logic [1:0]            fifo_cnt_q;
  logic                  pop, issue;

  assign pop = (fifo_cnt_q != 2'd0) & rready_i;
  // Count the beat still inside the RAM so the FIFO can never overflow.
  assign issue = (r_state_q == R_ISSUE) &&
                 (({1'b0, fifo_cnt_q} + {2'b00, infl_q} - {2'b00, pop}) < 3'd2);

  always_ff @(posedge aclk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      r_state_q   <= R_IDLE;
      arready_q   <= 1'b1;
      r_addr_q    <= '0;
      r_len_q     <= '0;
      r_cnt_q     <= '0;
      r_fixed_q   <= 1'b0;
      r_id_q      <= '0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
      infl_id_q   <= '0;
    end else begin
      infl_q      <= issue;
      infl_last_q <= (r_cnt_q == r_len_q);
      infl_id_q   <= r_id_q;
      if (r_state_q == R_IDLE) begin
        if (arvalid_i) begin
          r_id_q    <= arid_i;
          r_addr_q  <= araddr_i[ADDR_WIDTH+OFF-1:OFF];
          r_len_q   <= arlen_i;
          r_fixed_q <= (arburst_i == 2'b00);
          r_cnt_q   <= '0;
          arready_q <= 1'b0;
          r_state_q <= R_ISSUE;
        end
      end else if (issue) begin
        if (!r_fixed_q) r_addr_q <= r_addr_q + 1'b1;
        if (r_cnt_q == r_len_q) begin
          arready_q <= 1'b1;
          r_state_q <= R_IDLE;
        end else begin
          r_cnt_q <= r_cnt_q + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge aclk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      fifo_cnt_q <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        fifo_data_q[i] <= '0;
        fifo_id_q[i]   <= '0;
        fifo_last_q[i] <= 1'b0;
      end
    end else begin
      if (infl_q) begin
        fifo_data_q[wr_ptr_q] <= ram_rdata_b_i;
        fifo_id_q[wr_ptr_q]   <= infl_id_q;
        fifo_last_q[wr_ptr_q] <= infl_last_q;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      fifo_cnt_q <= fifo_cnt_q + {1'b0, infl_q} - {1'b0, pop};
    end
  end

  assign arready_o    = arready_q;
  assign ram_addr_b_o = r_addr_q;
  assign rvalid_o     = (fifo_cnt_q != 2'd0);
  assign rdata_o      = fifo_data_q[rd_ptr_q];
  assign rid_o        = fifo_id_q[rd_ptr_q];
  assign rlast_o      = fifo_last_q[rd_ptr_q];
  assign rresp_o      = 2'b00;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{awaddr_i, araddr_i};
endmodule

// File: tb/tb_axi_ram_slave.sv
// Bench for axi_ram_slave: behavioural RAM on both ports, word-level memory model, directed then random bursts.
module tb_axi_ram_slave;
  localparam int AW = 8, BW = 4, IDW = 4, AXW = 32, DW = 32, DEPTH = 256;

  logic aclk = 1'b0, aresetn = 1'b0;
  logic [IDW-1:0] awid, arid, bid, rid;
  logic [AXW-1:0] awaddr, araddr;
  logic [7:0] awlen, arlen;
  logic [1:0] awburst, arburst, bresp, rresp;
  logic awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic arvalid, arready, rlast, rvalid, rready;
  logic [DW-1:0] wdata, rdata, ram_wdata_a, ram_rdata_b;
  logic [BW-1:0] wstrb, ram_be_a;
  logic [AW-1:0] ram_addr_a, ram_addr_b;
  logic ram_we_a;

  axi_ram_slave #(.ADDR_WIDTH(AW), .BATCH_WIDTH(BW), .BYTE_WIDTH(8), .ID_WIDTH(IDW), .AXI_ADDR_WIDTH(AXW)) dut (
    .aclk_i(aclk), .aresetn_i(aresetn),
    .awid_i(awid), .awaddr_i(awaddr), .awlen_i(awlen), .awburst_i(awburst), .awvalid_i(awvalid), .awready_o(awready),
    .wdata_i(wdata), .wstrb_i(wstrb), .wlast_i(wlast), .wvalid_i(wvalid), .wready_o(wready),
    .bid_o(bid), .bresp_o(bresp), .bvalid_o(bvalid), .bready_i(bready),
    .arid_i(arid), .araddr_i(araddr), .arlen_i(arlen), .arburst_i(arburst), .arvalid_i(arvalid), .arready_o(arready),
    .rid_o(rid), .rdata_o(rdata), .rresp_o(rresp), .rlast_o(rlast), .rvalid_o(rvalid), .rready_i(rready),
    .ram_addr_a_o(ram_addr_a), .ram_wdata_a_o(ram_wdata_a), .ram_be_a_o(ram_be_a), .ram_we_a_o(ram_we_a),
    .ram_addr_b_o(ram_addr_b), .ram_rdata_b_i(ram_rdata_b)
  );

  always #5 aclk = ~aclk;

  int checks_cnt = 0, errors_cnt = 0, cyc = 0;
  logic [DW-1:0] ram_mem [DEPTH];
  logic [DW-1:0] exp_mem [DEPTH];
  int unsigned wr_log [$];

  always @(posedge aclk) cyc <= cyc + 1;

  // Behavioural dual-port RAM: byte-enabled write on a, registered read on b.
  always @(posedge aclk) begin
    if (ram_we_a)
      for (int b = 0; b < BW; b++)
        if (ram_be_a[b]) ram_mem[ram_addr_a][b*8 +: 8] <= ram_wdata_a[b*8 +: 8];
    ram_rdata_b <= ram_mem[ram_addr_b];
    if (aresetn && ram_we_a) wr_log.push_back(int'(ram_addr_a));
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp_v);
    checks_cnt++;
    if (got !== exp_v) begin
      errors_cnt++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp_v);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  function automatic int unsigned beat_addr(input int unsigned base, input int i, input logic [1:0] burst);
    return (burst == 2'b00) ? base : (base + i) % DEPTH;
  endfunction

  task automatic do_write(input logic [IDW-1:0] id, input int unsigned waddr, input int len,
                          input logic [1:0] burst, input int wlast_at, input bit rand_strb, input string tag);
    int n;
    int unsigned a;
    logic [DW-1:0] d;
    logic [BW-1:0] s;
    wr_log.delete();
    awid = id; awlen = 8'(len); awburst = burst; awvalid = 1'b1;
    awaddr = (waddr << 2) | $urandom_range(0, 3) | ($urandom & 32'hFFFF_FC00);
    n = 0;
    while (!awready && n < 100) begin step(); n++; end
    check_val({tag, "_aw_timeout"}, 64'(n < 100), 1);
    step();
    awvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      a = beat_addr(waddr, i, burst);
      d = $urandom;
      s = rand_strb ? BW'($urandom_range(0, 15)) : 4'hF;
      wdata = d; wstrb = s; wlast = (i == wlast_at); wvalid = 1'b1;
      n = 0;
      while (!wready && n < 100) begin step(); n++; end
      if (n >= 100) check_val({tag, "_w_timeout"}, 0, 1);
      step();
      for (int b = 0; b < BW; b++) if (s[b]) exp_mem[a][b*8 +: 8] = d[b*8 +: 8];
    end
    wvalid = 1'b0; wlast = 1'b0;
    bready = 1'b1;
    n = 0;
    while (!bvalid && n < 100) begin step(); n++; end
    check_val({tag, "_b_timeout"}, 64'(n < 100), 1);
    check_val({tag, "_bresp"}, bresp, (wlast_at == len) ? 2'b00 : 2'b10);
    check_val({tag, "_bid"}, bid, id);
    check_val({tag, "_awready_in_resp"}, awready, 0);
    step();
    bready = 1'b0;
    check_val({tag, "_awready_after_b"}, awready, 1);
    check_val({tag, "_bvalid_drop"}, bvalid, 0);
    check_val({tag, "_we_count"}, wr_log.size(), len + 1);
    for (int i = 0; i <= len && i < wr_log.size(); i++)
      check_val({tag, "_we_addr"}, wr_log[i], beat_addr(waddr, i, burst));
    $display("WRITE %s id=%0h word=%0d len=%0d burst=%0d", tag, id, waddr, len, burst);
  endtask

  // mode: 0 rready held high, 1 toggling, 2 random
  task automatic do_read(input logic [IDW-1:0] id, input int unsigned waddr, input int len,
                         input logic [1:0] burst, input int mode, input bit chk_lat, input string tag);
    int n, beat, t0;
    bit first, stalled;
    logic [DW-1:0] p_data;
    logic [IDW-1:0] p_id;
    logic p_last;
    arid = id; arlen = 8'(len); arburst = burst; arvalid = 1'b1;
    araddr = (waddr << 2) | $urandom_range(0, 3) | ($urandom & 32'hFFFF_FC00);
    n = 0;
    while (!arready && n < 100) begin step(); n++; end
    check_val({tag, "_ar_timeout"}, 64'(n < 100), 1);
    t0 = cyc;
    step();
    arvalid = 1'b0;
    beat = 0; first = 1'b1; stalled = 1'b0; n = 0;
    p_data = '0; p_id = '0; p_last = 1'b0;
    while (beat <= len && n < 400) begin
      rready = (mode == 0) ? 1'b1 : (mode == 1) ? ((n % 2) == 0) : 1'($urandom_range(0, 1));
      #1;
      if (stalled) begin
        check_val({tag, "_stall_valid"}, rvalid, 1);
        check_val({tag, "_stall_data"}, rdata, p_data);
        check_val({tag, "_stall_id"}, rid, p_id);
        check_val({tag, "_stall_last"}, rlast, p_last);
      end
      if (rvalid && first) begin
        if (chk_lat) check_val({tag, "_latency"}, cyc - t0, 3);
        first = 1'b0;
      end
      if (rvalid && rready) begin
        check_val({tag, "_rdata"}, rdata, exp_mem[beat_addr(waddr, beat, burst)]);
        check_val({tag, "_rid"}, rid, id);
        check_val({tag, "_rlast"}, rlast, beat == len);
        check_val({tag, "_rresp"}, rresp, 0);
        beat++;
      end
      stalled = rvalid && !rready;
      p_data = rdata; p_id = rid; p_last = rlast;
      step();
      n++;
    end
    check_val({tag, "_beats"}, beat, len + 1);
    rready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1 check_val({tag, "_no_extra_beat"}, rvalid, 0);
      step();
    end
    rready = 1'b0;
    $display("READ  %s id=%0h word=%0d len=%0d burst=%0d mode=%0d", tag, id, waddr, len, burst, mode);
  endtask

  initial begin
    int n, got;
    logic [DW-1:0] v;
    awid = '0; awaddr = '0; awlen = '0; awburst = '0; awvalid = 0;
    wdata = '0; wstrb = '0; wlast = 0; wvalid = 0; bready = 0;
    arid = '0; araddr = '0; arlen = '0; arburst = '0; arvalid = 0; rready = 0;
    for (int i = 0; i < DEPTH; i++) begin
      v = $urandom;
      ram_mem[i] = v;
      exp_mem[i] = v;
    end
    repeat (3) @(posedge aclk);
    #1;
    check_val("rst_awready", awready, 1);
    check_val("rst_arready", arready, 1);
    check_val("rst_wready", wready, 0);
    check_val("rst_bvalid", bvalid, 0);
    check_val("rst_rvalid", rvalid, 0);
    check_val("rst_we_a", ram_we_a, 0);
    check_val("rst_bresp_bid", {bresp, bid}, 0);
    check_val("rst_r_outputs", {rid, rdata, rlast}, 0);
    check_val("rst_ram_addrs", {ram_addr_a, ram_addr_b}, 0);
    aresetn = 1'b1;
    step();

    do_write(4'h3, 4, 3, 2'b01, 3, 1'b0, "t1_incr");
    do_read (4'h5, 4, 3, 2'b01, 0, 1'b1, "t2_read");
    do_read (4'h6, 4, 3, 2'b01, 1, 1'b1, "t3_toggle");
    do_write(4'h7, 20, 1, 2'b01, 0, 1'b0, "t4_early_wlast");
    do_read (4'h7, 20, 1, 2'b01, 0, 1'b1, "t4_read");
    do_write(4'h8, DEPTH - 1, 1, 2'b01, 1, 1'b0, "t5_wrap");
    do_read (4'h8, DEPTH - 1, 1, 2'b01, 2, 1'b1, "t5_wrap_read");
    do_write(4'h9, 100, 2, 2'b00, 2, 1'b1, "t5_fixed");
    do_read (4'h9, 100, 2, 2'b00, 2, 1'b1, "t5_fixed_read");
    do_write(4'hA, 50, 5, 2'b10, 5, 1'b1, "t5_wrap_as_incr");
    do_read (4'hA, 50, 5, 2'b10, 2, 1'b1, "t5_wrap_as_incr_read");

    // Reset while beat 2 of a len-3 read is presented.
    arid = 4'h1; araddr = 32'(8 << 2); arlen = 8'd3; arburst = 2'b01; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 100) begin step(); n++; end
    step();
    arvalid = 1'b0; rready = 1'b1;
    n = 0; got = 0;
    while (got < 1 && n < 50) begin if (rvalid) got++; step(); n++; end
    check_val("t6_first_beat_seen", got, 1);
    check_val("t6_second_beat_valid", rvalid, 1);
    aresetn = 1'b0;
    #1;
    check_val("t6_rvalid_in_reset", rvalid, 0);
    check_val("t6_arready_in_reset", arready, 1);
    @(posedge aclk);
    #2 aresetn = 1'b1;
    rready = 1'b0;
    step();
    check_val("t6_rvalid_after", rvalid, 0);
    check_val("t6_arready_after", arready, 1);
    check_val("t6_bvalid_after", bvalid, 0);
    do_read(4'h2, 8, 3, 2'b01, 0, 1'b1, "t6_fresh_read");

    for (int t = 0; t < 25; t++) begin
      int unsigned a;
      int len, wl;
      logic [1:0] bu;
      a = $urandom_range(0, DEPTH - 1);
      len = $urandom_range(0, 7);
      bu = 2'($urandom_range(0, 2));
      wl = ($urandom_range(0, 4) == 0) ? $urandom_range(0, len + 1) : len;
      do_write(IDW'($urandom), a, len, bu, wl, 1'b1, "rnd_wr");
      do_read(IDW'($urandom), $urandom_range(0, DEPTH - 1), $urandom_range(0, 7),
              2'($urandom_range(0, 2)), 2, 1'b1, "rnd_rd");
    end

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=%0d expected=%0d", cyc, 0);
    $fatal(1, "timeout");
  end
endmodule
